fwd_hazard_unit: RTL

- Pipeline control block that produces the operand-forwarding selects and SP-forward select consumed by the execute stage.
- Also generates load-use stall and bubble control.
- Keeps a shadow scoreboard of destination info for the instructions in X, M and W; compares it against the decode-stage sources; registers the selects so they are valid during the consuming instruction's X cycle.
- Sits beside decode; drives the execute-stage forwarding inputs and the PC/IF-ID stall and X bubble.

---
 rtl/fwd_hazard_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard control for the execute stage.
// Optional performance counters are enabled with HAZ_PERF_CNT_EN.
module fwd_hazard_unit #(
  parameter int REG_AW      = 5,
  parameter int SCORE_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              D_valid,
  input  logic [REG_AW-1:0] D_rs0,
  input  logic [REG_AW-1:0] D_rs1,
  input  logic [REG_AW-1:0] D_rd,
  input  logic              D_we,
  input  logic              D_isLoad,
  input  logic              D_usesSP,
  input  logic              D_writesSP,
  input  logic              flush,
  input  logic              mem_busy,
  output logic              M_X_r0,
  output logic              M_X_r1,
  output logic              W_X_r0,
  output logic              W_X_r1,
  output logic              SP_forw,
  output logic              stall_D,
  output logic              bubble_X
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              is_load;
    logic              writes_sp;
  } sb_entry_t;

  localparam int SX = 0;
  localparam int SM = 1;
  localparam int SW = 2;

  if (SCORE_DEPTH != 3) begin : g_depth_check
    $error("fwd_hazard_unit: SCORE_DEPTH must be 3");
  end

  sb_entry_t  sb_q [SCORE_DEPTH];
  sb_entry_t  sb_d [SCORE_DEPTH];
  sb_entry_t  d_entry;
  // select vector order: {SP_forw, W_X_r1, W_X_r0, M_X_r1, M_X_r0}
  logic [4:0] sel_q;
  logic [4:0] sel_d;
  logic       match_x0, match_x1, match_m0, match_m1;
  logic       load_use, kill_x;

  function automatic logic match_f(input sb_entry_t e, input logic [REG_AW-1:0] rs);
    match_f = e.valid & e.we & (e.rd == rs) & (rs != {REG_AW{1'b0}});
  endfunction

  // Hazard detection against the X and M scoreboard entries
  always_comb begin
    match_x0 = match_f(sb_q[SX], D_rs0);
    match_x1 = match_f(sb_q[SX], D_rs1);
    match_m0 = match_f(sb_q[SM], D_rs0);
    match_m1 = match_f(sb_q[SM], D_rs1);
    load_use = D_valid & ~flush & ~mem_busy & sb_q[SX].is_load & (match_x0 | match_x1);
    kill_x   = flush | load_use;
    stall_D  = rst_n & (mem_busy | load_use);
    bubble_X = rst_n & ~mem_busy & kill_x;
  end

  // Scoreboard shift and select computation; mem_busy freezes everything
  always_comb begin
    for (int i = 0; i < SCORE_DEPTH; i++) begin
      sb_d[i] = sb_q[i];
    end
    sel_d = sel_q;
    if (D_valid) begin
      d_entry = {1'b1, D_rd, D_we, D_isLoad, D_writesSP};
    end else begin
      d_entry = '0;
    end
    if (mem_busy) begin
      sel_d = sel_q;
    end else begin
      sb_d[SW] = sb_q[SM];
      sb_d[SM] = sb_q[SX];
      if (kill_x) begin
        sb_d[SX] = '0;
        sel_d    = 5'b0_0000;
      end else begin
        sb_d[SX] = d_entry;
        sel_d[0] = D_valid & match_x0 & ~sb_q[SX].is_load;
        sel_d[1] = D_valid & match_x1 & ~sb_q[SX].is_load;
        sel_d[2] = D_valid & match_m0 & ~match_x0;
        sel_d[3] = D_valid & match_m1 & ~match_x1;
        sel_d[4] = D_valid & D_usesSP & sb_q[SX].valid & sb_q[SX].writes_sp;
      end
    end
  end

  // Scoreboard and select registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SCORE_DEPTH; i++) begin
        sb_q[i] <= '0;
      end
      sel_q <= 5'b0_0000;
    end else begin
      for (int i = 0; i < SCORE_DEPTH; i++) begin
        sb_q[i] <= sb_d[i];
      end
      sel_q <= sel_d;
    end
  end

  assign M_X_r0  = sel_q[0];
  assign M_X_r1  = sel_q[1];
  assign W_X_r0  = sel_q[2];
  assign W_X_r1  = sel_q[3];
  assign SP_forw = sel_q[4];

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (load_use && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
